rap_acc_adder: RTL and testbench
================================

Name: rap_acc_adder

Overview:
- Parametrised, handshaked approximate adder: successor to the fixed 32-bit, window-8 RAP-CLA carry-truncation adder.
- Produces the windowed approximate sum by default. It flags operand pairs whose carry chain may exceed the window.
- In accurate mode it repairs flagged results with a multi-cycle segmented exact add.
- Sits between operand producers and accumulators in the approximate-datapath experiments. Allows a run-time accuracy/latency trade-off.

Parameters:
WIDTH, 32, operand width in bits (sum is WIDTH+1).
WIN, 8, carry window: appc[i] considers generates g[j] for j in [max(0,i-WIN), i] only.
SEG, 8, bits processed per correction cycle; NSEG = ceil(WIDTH/SEG).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept operands.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
mode  in  1  0 = approximate only, 1 = accurate (correct when flagged); sampled with operands.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sum  out  WIDTH+1  result.
approx_flag  out  1  suspect carry chain detected for this result.
corrected  out  1  result produced by the correction path.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; in_ready=1; out_valid=0; sum=0; approx_flag=0; corrected=0.
  - Segment counter and carry register cleared.
  - Reset mid-operation discards the transaction, with no output.
- Definitions on registered operands:
  - p=a^b, g=a&b.
  - appc[i] = OR over j in [max(0,i-WIN), i] of g[j] & AND(p[j+1..i]).
  - approx sum: sum[0]=p[0]; sum[i]=p[i]^appc[i-1] for 1<=i<WIDTH; sum[WIDTH]=appc[WIDTH-1].
  - suspect = OR over i in [WIN, WIDTH-1] of AND(p[i-WIN..i]), i.e. any run of WIN+1 consecutive propagate bits. This is a conservative superset of approximation error; when suspect=0 the approx sum equals the exact sum.
- FSM states: IDLE, CALC, CORR, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready, register a, b, mode and go to CALC. The accepting edge is E0.
  - CALC (in_ready=0):
    - If mode=0 or suspect=0: load sum=approx sum, approx_flag=suspect, corrected=0, go to OUT.
    - Else: clear seg counter k=0 and carry cr=0, go to CORR.
  - CORR:
    - Each cycle computes bits [k*SEG, min((k+1)*SEG, WIDTH)-1] exactly as a+b+cr, writes them into the sum register, latches the segment carry-out into cr, and increments k.
    - The final segment may be narrower than SEG.
    - After segment NSEG-1: sum[WIDTH]=final carry, approx_flag=1, corrected=1, go to OUT.
  - OUT:
    - out_valid=1; sum, approx_flag and corrected held stable.
    - On out_ready go to IDLE, dropping out_valid the next cycle.
    - in_ready=0 while out_valid=1 (no overlap).
- Latency from E0:
  - Fast path: out_valid high after edge E0+1.
  - Corrected path: out_valid high after edge E0+1+NSEG (E0+5 at defaults).
  - Throughput: at most one transaction per (latency+1) cycles.
- Boundaries:
  - Carry out of bit WIDTH-1 always lands in sum[WIDTH].
  - WIN >= WIDTH-1 makes suspect constant 0 (exact adder, fast path only).
  - SEG >= WIDTH gives NSEG=1.
  - Legal ranges: 1<=WIN, 1<=SEG<=WIDTH, WIDTH>=2.
  - Operands and mode are ignored outside IDLE.

Test Plan:
1. Reset, then idle -> in_ready=1, out_valid=0, sum=0, approx_flag=0, corrected=0; assert rst_n low mid-CORR -> out_valid stays 0, in_ready=1 after release, no output.
2. Defaults, mode=1, a=0x000000FF, b=0x00000001 -> sum=0x100, approx_flag=0, corrected=0, out_valid after E0+1.
3. mode=0, a=0x0000FFFF, b=0x00000001 -> sum=0x0000FC00 (truncated carry), approx_flag=1, corrected=0, out_valid after E0+1.
4. mode=1, same operands -> sum=0x00010000, approx_flag=1, corrected=1, out_valid after E0+5; mode=1, a=0x0000FFFE, b=0 (false suspect) -> sum=0x0000FFFE, corrected=1.
5. mode=1, a=0xFFFFFFFF, b=0x00000001 -> sum=0x1_00000000, corrected=1; then hold out_ready=0 for 5 cycles -> out_valid, sum and flags stable, in_ready=0; release -> IDLE next cycle.
6. Random regression, WIDTH=16/WIN=4/SEG=5 and defaults, mode=1 -> sum always equals a+b; mode=0 with approx_flag=0 -> sum equals a+b.

Source files
------------

// File: rtl/rap_acc_adder.sv
// Handshaked windowed-carry approximate adder with an optional multi-cycle
// segmented exact repair path for operand pairs whose carry chain may exceed the window.
module rap_acc_adder #(
    parameter int WIDTH = 32,
    parameter int WIN   = 8,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             approx_flag,
    output logic             corrected
);

    localparam int NSEG   = (WIDTH + SEG - 1) / SEG;
    localparam int KW     = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int LAST_W = WIDTH - (NSEG - 1) * SEG;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CORR,
        OUT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             mode_reg;
    logic [KW-1:0]    seg_idx;
    logic             carry_reg;
    logic [WIDTH:0]   sum_reg;
    logic             flag_reg, corr_reg;

    logic [WIDTH-1:0] p, g;
    logic [WIDTH-1:0] appc;
    logic             run;
    int               run_len;
    logic             suspect_raw, suspect;
    logic [WIDTH:0]   approx_sum;

    assign p = a_reg ^ b_reg;
    assign g = a_reg & b_reg;

    // Windowed carry: only generates within WIN bits below position i may reach it.
    always_comb begin
        appc = '0;
        run  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                if (i - j <= WIN) begin
                    appc[i] = appc[i] | (g[j] & run);
                end
                run = run & p[j];
            end
        end
    end

    always_comb begin
        approx_sum    = '0;
        approx_sum[0] = p[0];
        for (int i = 1; i < WIDTH; i++) begin
            approx_sum[i] = p[i] ^ appc[i-1];
        end
        approx_sum[WIDTH] = appc[WIDTH-1];
    end

    always_comb begin
        suspect_raw = 1'b0;
        run_len     = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (p[i]) begin
                run_len = run_len + 1;
            end else begin
                run_len = 0;
            end
            if (run_len > WIN) begin
                suspect_raw = 1'b1;
            end
        end
    end

    // A window spanning the whole word already sees every generate, so nothing is suspect.
    assign suspect = (WIN >= WIDTH - 1) ? 1'b0 : suspect_raw;

    logic [WIDTH-1:0] a_shift, b_shift;
    logic [SEG-1:0]   seg_a, seg_b;
    logic [SEG:0]     seg_sum;
    logic             seg_carry;
    logic             last_seg;
    logic [WIDTH:0]   seg_mask, seg_bits, corr_sum;
    int               base;

    always_comb begin
        base      = int'(seg_idx) * SEG;
        a_shift   = a_reg >> base;
        b_shift   = b_reg >> base;
        seg_a     = a_shift[SEG-1:0];
        seg_b     = b_shift[SEG-1:0];
        seg_sum   = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_reg};
        last_seg  = (seg_idx == KW'(NSEG - 1));
        seg_carry = last_seg ? seg_sum[LAST_W] : seg_sum[SEG];
        seg_mask  = ({{(WIDTH + 1 - SEG){1'b0}}, {SEG{1'b1}}} << base) & {1'b0, {WIDTH{1'b1}}};
        seg_bits  = (WIDTH + 1)'(seg_sum[SEG-1:0]) << base;
        corr_sum  = (sum_reg & ~seg_mask) | (seg_bits & seg_mask);
        if (last_seg) begin
            corr_sum[WIDTH] = seg_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CALC;
            CALC: state_next = (!mode_reg || !suspect) ? OUT : CORR;
            CORR: if (last_seg) state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= 1'b0;
            seg_idx   <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            flag_reg  <= 1'b0;
            corr_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        mode_reg <= mode;
                    end
                end
                CALC: begin
                    if (!mode_reg || !suspect) begin
                        sum_reg  <= approx_sum;
                        flag_reg <= suspect;
                        corr_reg <= 1'b0;
                    end else begin
                        seg_idx   <= '0;
                        carry_reg <= 1'b0;
                    end
                end
                CORR: begin
                    sum_reg   <= corr_sum;
                    carry_reg <= seg_carry;
                    seg_idx   <= seg_idx + KW'(1);
                    if (last_seg) begin
                        flag_reg <= 1'b1;
                        corr_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT);
    assign sum         = sum_reg;
    assign approx_flag = flag_reg;
    assign corrected   = corr_reg;

endmodule

// File: tb/tb_rap_acc_adder.sv
// Directed and randomized checks of rap_acc_adder at default parameters and at
// WIDTH=16/WIN=4/SEG=5.
module tb_rap_acc_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic        mode = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [32:0] sum;
    logic        approx_flag, corrected;

    logic        in_valid16 = 1'b0, in_ready16;
    logic [15:0] a16 = '0, b16 = '0;
    logic        mode16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b0;
    logic [16:0] sum16;
    logic        approx_flag16, corrected16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rap_acc_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .approx_flag(approx_flag), .corrected(corrected)
    );

    rap_acc_adder #(.WIDTH(16), .WIN(4), .SEG(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .approx_flag(approx_flag16), .corrected(corrected16)
    );

    // Drives one transaction, scrambles operands after acceptance, and reports the
    // number of edges after the accepting edge until out_valid (or -1 on timeout).
    task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic tm,
                           input bit consume, output int lat,
                           output logic [32:0] s, output logic f, output logic c);
        @(negedge clk);
        a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h5A5A5A5A; mode = ~tm;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        s = sum; f = approx_flag; c = corrected;
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic run_txn16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm,
                             output int lat, output logic [16:0] s, output logic f);
        @(negedge clk);
        a16 = ta; b16 = tb_v; mode16 = tm; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid16 !== 1'b1) lat = -1;
        s = sum16; f = approx_flag16;
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, out_valid, approx_flag, corrected, sum} !== {4'b1000, 33'h0}) begin
            failures++;
            $display("[TB] FAIL reset_held: got rdy=%b vld=%b flag=%b corr=%b sum=%h expected 1 0 0 0 0",
                     in_ready, out_valid, approx_flag, corrected, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({sum, approx_flag, corrected} !== 35'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got sum=%h flag=%b corr=%b expected 0", sum, approx_flag, corrected);
        end
    endtask

    task automatic test_fast_exact();
        int lat; logic [32:0] s; logic f, c;
        run_txn(32'h000000FF, 32'h00000001, 1'b1, 1'b1, lat, s, f, c);
        checks++;
        if (lat !== 1) begin failures++; $display("[TB] FAIL fast_latency: got %0d expected 1", lat); end
        checks++;
        if (s !== 33'h100) begin failures++; $display("[TB] FAIL fast_sum: got %h expected 100", s); end
        checks++;
        if ({f, c} !== 2'b00) begin failures++; $display("[TB] FAIL fast_flags: got %b%b expected 00", f, c); end
    endtask

    task automatic test_truncated();
        int lat; logic [32:0] s; logic f, c;
        run_txn(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, lat, s, f, c);
        checks++;
        if (lat !== 1) begin failures++; $display("[TB] FAIL trunc_latency: got %0d expected 1", lat); end
        checks++;
        if (s !== 33'h0000FC00) begin failures++; $display("[TB] FAIL trunc_sum: got %h expected 0000fc00", s); end
        checks++;
        if ({f, c} !== 2'b10) begin failures++; $display("[TB] FAIL trunc_flags: got %b%b expected 10", f, c); end
    endtask

    task automatic test_corrected();
        int lat; logic [32:0] s; logic f, c;
        run_txn(32'h0000FFFF, 32'h00000001, 1'b1, 1'b1, lat, s, f, c);
        checks++;
        if (lat !== 5) begin failures++; $display("[TB] FAIL corr_latency: got %0d expected 5", lat); end
        checks++;
        if (s !== 33'h00010000) begin failures++; $display("[TB] FAIL corr_sum: got %h expected 00010000", s); end
        checks++;
        if ({f, c} !== 2'b11) begin failures++; $display("[TB] FAIL corr_flags: got %b%b expected 11", f, c); end
        run_txn(32'h0000FFFE, 32'h00000000, 1'b1, 1'b1, lat, s, f, c);
        checks++;
        if (lat !== 5) begin failures++; $display("[TB] FAIL false_suspect_latency: got %0d expected 5", lat); end
        checks++;
        if ({s, f, c} !== {33'h0000FFFE, 2'b11}) begin
            failures++;
            $display("[TB] FAIL false_suspect: got sum=%h flags=%b%b expected 0000fffe 11", s, f, c);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [32:0] s; logic f, c;
        run_txn(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, lat, s, f, c);
        checks++;
        if ({s, f, c} !== {33'h1_0000_0000, 2'b11} || lat !== 5) begin
            failures++;
            $display("[TB] FAIL carry_out_corr: got sum=%h flags=%b%b lat=%0d expected 100000000 11 5", s, f, c, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, approx_flag, corrected, sum} !== {4'b1011, 33'h1_0000_0000}) begin
                failures++;
                $display("[TB] FAIL hold_stable: cycle %0d got vld=%b rdy=%b flag=%b corr=%b sum=%h expected 1 0 1 1 100000000",
                         i, out_valid, in_ready, approx_flag, corrected, sum);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL release_idle: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_corr();
        int lat; logic [32:0] s; logic f, c;
        bit saw_valid;
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'h00000001; mode = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum} !== {2'b10, 33'h0}) begin
            failures++;
            $display("[TB] FAIL mid_reset_async: got rdy=%b vld=%b sum=%h expected 1 0 0", in_ready, out_valid, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("[TB] FAIL mid_reset_discard: got an output or busy state after reset, expected idle");
        end
        run_txn(32'h00000003, 32'h00000004, 1'b0, 1'b1, lat, s, f, c);
        checks++;
        if ({s, f, c} !== {33'h7, 2'b00} || lat !== 1) begin
            failures++;
            $display("[TB] FAIL post_reset_txn: got sum=%h flags=%b%b lat=%0d expected 7 00 1", s, f, c, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [32:0] s; logic f, c;
        logic [16:0] s16; logic f16;
        logic [31:0] ra, rb;
        logic [15:0] ra16, rb16;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ~ra : ((i % 3 == 1) ? (~ra ^ 32'h1) : $urandom);
            run_txn(ra, rb, 1'b1, 1'b1, lat, s, f, c);
            checks++;
            if (s !== ({1'b0, ra} + {1'b0, rb}) || lat < 0) begin
                failures++;
                $display("[TB] FAIL rand32_accurate: a=%h b=%h got %h expected %h", ra, rb, s, {1'b0, ra} + {1'b0, rb});
            end
            run_txn(ra, rb, 1'b0, 1'b1, lat, s, f, c);
            checks++;
            if (lat !== 1 || (f === 1'b0 && s !== ({1'b0, ra} + {1'b0, rb}))) begin
                failures++;
                $display("[TB] FAIL rand32_approx: a=%h b=%h got %h lat=%0d expected %h lat=1", ra, rb, s, lat, {1'b0, ra} + {1'b0, rb});
            end
        end
        for (int i = 0; i < 24; i++) begin
            ra16 = 16'($urandom);
            rb16 = (i % 2 == 0) ? ~ra16 : 16'($urandom);
            run_txn16(ra16, rb16, 1'b1, lat, s16, f16);
            checks++;
            if (s16 !== ({1'b0, ra16} + {1'b0, rb16}) || lat < 0) begin
                failures++;
                $display("[TB] FAIL rand16_accurate: a=%h b=%h got %h expected %h", ra16, rb16, s16, {1'b0, ra16} + {1'b0, rb16});
            end
            run_txn16(ra16, rb16, 1'b0, lat, s16, f16);
            checks++;
            if (lat !== 1 || (f16 === 1'b0 && s16 !== ({1'b0, ra16} + {1'b0, rb16}))) begin
                failures++;
                $display("[TB] FAIL rand16_approx: a=%h b=%h got %h lat=%0d expected %h lat=1", ra16, rb16, s16, lat, {1'b0, ra16} + {1'b0, rb16});
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fast_exact();
        test_truncated();
        test_corrected();
        test_backpressure();
        test_reset_mid_corr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
